audio_mixer_n: RTL and testbench

- Parametrised N-channel stereo mixer. Successor to the fixed two-source adder in the audio top level.
- Snapshots N signed stereo sources on each next_sample strobe and applies a 4-bit gain to each channel, with per-channel mute.
- Sums the channels sequentially (one channel per clock), then applies a master gain and saturates to the DAC width.
- Presents a registered stereo sample with a one-cycle valid pulse to the I2S DAC interface.

---
 rtl/audio_mixer_n.sv | 158 +++++++++++++++
 tb/tb_audio_mixer_n.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mixer_n.sv
// N-channel stereo mixer: snapshot on next_sample, sequential per-channel gain/accumulate,
// master gain, saturation to OUT_W and a one-cycle valid pulse toward the DAC.

module audio_mixer_n_lane #(
  parameter int IN_W  = 23,
  parameter int ACC_W = 31
) (
  input  logic signed [IN_W-1:0]  left,
  input  logic signed [IN_W-1:0]  right,
  input  logic [3:0]              vol,
  input  logic                    mute,
  output logic signed [ACC_W-1:0] prod_l,
  output logic signed [ACC_W-1:0] prod_r
);
  // code 15 is unity (16/16), so the gain needs five bits
  logic [4:0]              g;
  logic signed [ACC_W-1:0] gs;

  assign g      = mute ? 5'd0 : ((vol == 4'd15) ? 5'd16 : {1'b0, vol});
  assign gs     = ACC_W'($signed({1'b0, g}));
  assign prod_l = ACC_W'(left) * gs;
  assign prod_r = ACC_W'(right) * gs;
endmodule

module audio_mixer_n #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 23,
  parameter int OUT_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     next_sample,
  input  logic [NUM_CH*IN_W-1:0]   in_left,
  input  logic [NUM_CH*IN_W-1:0]   in_right,
  input  logic [NUM_CH*4-1:0]      ch_volume,
  input  logic [NUM_CH-1:0]        ch_mute,
  input  logic [3:0]               master_volume,
  input  logic                     clip_clear,
  output logic signed [OUT_W-1:0]  out_left,
  output logic signed [OUT_W-1:0]  out_right,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     clip_left,
  output logic                     clip_right,
  output logic                     overrun
);
  localparam int ACC_W = IN_W + 5 + $clog2(NUM_CH) + 1;
  localparam int KW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WW    = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic signed [WW-1:0] SAT_MAX = WW'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [WW-1:0] SAT_MIN = -SAT_MAX - WW'(1);

  typedef enum logic [1:0] {IDLE, ACC, MASTER, OUT} state_t;

  state_t                           state;
  logic [KW-1:0]                    k;
  logic [NUM_CH-1:0][IN_W-1:0]      snap_l, snap_r;
  logic [NUM_CH-1:0][3:0]           snap_vol;
  logic [NUM_CH-1:0]                snap_mute;
  logic [3:0]                       snap_master;
  logic signed [ACC_W-1:0]          acc_l, acc_r;
  logic signed [ACC_W-1:0]          prod_l [NUM_CH];
  logic signed [ACC_W-1:0]          prod_r [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    audio_mixer_n_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane (
      .left   (snap_l[i]),
      .right  (snap_r[i]),
      .vol    (snap_vol[i]),
      .mute   (snap_mute[i]),
      .prod_l (prod_l[i]),
      .prod_r (prod_r[i])
    );
  end

  logic [4:0]              gm;
  logic signed [ACC_W-1:0] gm_s, mst_l, mst_r;
  logic signed [WW-1:0]    r_l, r_r, sat_l, sat_r;
  logic                    hi_l, lo_l, hi_r, lo_r;

  assign gm    = (snap_master == 4'd15) ? 5'd16 : {1'b0, snap_master};
  assign gm_s  = ACC_W'($signed({1'b0, gm}));
  assign mst_l = (acc_l >>> 4) * gm_s;
  assign mst_r = (acc_r >>> 4) * gm_s;
  assign r_l   = WW'(acc_l >>> 4);
  assign r_r   = WW'(acc_r >>> 4);
  assign hi_l  = r_l > SAT_MAX;
  assign lo_l  = r_l < SAT_MIN;
  assign hi_r  = r_r > SAT_MAX;
  assign lo_r  = r_r < SAT_MIN;
  assign sat_l = hi_l ? SAT_MAX : (lo_l ? SAT_MIN : r_l);
  assign sat_r = hi_r ? SAT_MAX : (lo_r ? SAT_MIN : r_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= '0;
      snap_l      <= '0;
      snap_r      <= '0;
      snap_vol    <= '0;
      snap_mute   <= '0;
      snap_master <= '0;
      acc_l       <= '0;
      acc_r       <= '0;
      out_left    <= '0;
      out_right   <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      clip_left   <= 1'b0;
      clip_right  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      // clear first so a same-cycle set below takes priority
      if (clip_clear) begin
        clip_left  <= 1'b0;
        clip_right <= 1'b0;
        overrun    <= 1'b0;
      end
      if (next_sample && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (next_sample) begin
          snap_l      <= in_left;
          snap_r      <= in_right;
          snap_vol    <= ch_volume;
          snap_mute   <= ch_mute;
          snap_master <= master_volume;
          acc_l       <= '0;
          acc_r       <= '0;
          k           <= '0;
          busy        <= 1'b1;
          state       <= ACC;
        end
        ACC: begin
          acc_l <= acc_l + prod_l[k];
          acc_r <= acc_r + prod_r[k];
          if (k == KW'(NUM_CH-1)) state <= MASTER;
          else                    k     <= k + 1'b1;
        end
        MASTER: begin
          acc_l <= mst_l;
          acc_r <= mst_r;
          state <= OUT;
        end
        OUT: begin
          out_left  <= OUT_W'(sat_l);
          out_right <= OUT_W'(sat_r);
          out_valid <= 1'b1;
          busy      <= 1'b0;
          if (hi_l || lo_l) clip_left  <= 1'b1;
          if (hi_r || lo_r) clip_right <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_audio_mixer_n.sv
// Directed bench for audio_mixer_n: arithmetic model with per-cycle compare plus literal checks.

module tb_audio_mixer_n;
  localparam int NUM_CH = 4;
  localparam int IN_W   = 23;
  localparam int OUT_W  = 24;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    next_sample = 1'b0;
  logic [NUM_CH*IN_W-1:0]  in_left, in_right;
  logic [NUM_CH*4-1:0]     ch_volume;
  logic [NUM_CH-1:0]       ch_mute;
  logic [3:0]              master_volume;
  logic                    clip_clear = 1'b0;
  logic signed [OUT_W-1:0] out_left, out_right;
  logic                    out_valid, busy, clip_left, clip_right, overrun;

  int sl [NUM_CH];
  int sr [NUM_CH];
  int vol [NUM_CH];
  bit mute [NUM_CH];
  int mvol;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    in_left   = '0;
    in_right  = '0;
    ch_volume = '0;
    ch_mute   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_left[i*IN_W +: IN_W]  = IN_W'(sl[i]);
      in_right[i*IN_W +: IN_W] = IN_W'(sr[i]);
      ch_volume[i*4 +: 4]      = 4'(vol[i]);
      ch_mute[i]               = mute[i];
    end
    master_volume = 4'(mvol);
  end

  audio_mixer_n #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .next_sample(next_sample),
    .in_left(in_left), .in_right(in_right), .ch_volume(ch_volume), .ch_mute(ch_mute),
    .master_volume(master_volume), .clip_clear(clip_clear),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid), .busy(busy),
    .clip_left(clip_left), .clip_right(clip_right), .overrun(overrun)
  );

  // ---------------- behavioural model ----------------
  function automatic longint gain(input int code);
    return (code == 15) ? 64'sd16 : longint'(code);
  endfunction

  function automatic longint floor16(input longint a);
    longint q;
    q = a / 16;
    if ((a % 16) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint mix(input bit right, output bit clipped);
    longint s, r, lim;
    s = 0;
    for (int i = 0; i < NUM_CH; i++)
      s += longint'(right ? sr[i] : sl[i]) * (mute[i] ? 64'sd0 : gain(vol[i]));
    r   = floor16(floor16(s) * gain(mvol));
    lim = 64'sd1 << (OUT_W-1);
    clipped = (r > lim - 1) || (r < -lim);
    if (r > lim - 1) r = lim - 1;
    if (r < -lim)    r = -lim;
    return r;
  endfunction

  int     m_cnt = 0;
  bit     m_busy = 0, m_valid = 0, m_cl = 0, m_cr = 0, m_ov = 0;
  longint m_l = 0, m_r = 0, p_l = 0, p_r = 0;
  bit     p_cl = 0, p_cr = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_busy <= 0; m_valid <= 0; m_cl <= 0; m_cr <= 0; m_ov <= 0;
      m_l <= 0; m_r <= 0;
    end else begin
      bit cl, cr;
      longint vl, vr;
      m_valid <= 0;
      if (clip_clear) begin m_cl <= 0; m_cr <= 0; m_ov <= 0; end
      if (m_busy) begin
        if (next_sample) m_ov <= 1;
        if (m_cnt == 1) begin
          m_l <= p_l; m_r <= p_r; m_valid <= 1; m_busy <= 0;
          if (p_cl) m_cl <= 1;
          if (p_cr) m_cr <= 1;
        end
        m_cnt <= m_cnt - 1;
      end else if (next_sample) begin
        vl = mix(1'b0, cl);
        vr = mix(1'b1, cr);
        p_l <= vl; p_r <= vr; p_cl <= cl; p_cr <= cr;
        m_cnt <= NUM_CH + 2;
        m_busy <= 1;
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (out_valid !== m_valid || busy !== m_busy || longint'(out_left) != m_l ||
        longint'(out_right) != m_r || clip_left !== m_cl || clip_right !== m_cr || overrun !== m_ov) begin
      errors++;
      $display("FAIL cycle_compare t=%0t got v%b b%b L%0d R%0d cl%b cr%b ov%b want v%b b%b L%0d R%0d cl%b cr%b ov%b",
               $time, out_valid, busy, out_left, out_right, clip_left, clip_right, overrun,
               m_valid, m_busy, m_l, m_r, m_cl, m_cr, m_ov);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic setch(input int i, input int l, input int r, input int v, input bit m);
    sl[i] = l; sr[i] = r; vol[i] = v; mute[i] = m;
  endtask

  task automatic solo(input int l, input int r, input int v, input int mv);
    setch(0, l, r, v, 1'b0);
    for (int i = 1; i < NUM_CH; i++) setch(i, 777, -777, 15, 1'b1);
    mvol = mv;
  endtask

  task automatic run_mix(input string nm, input longint el, input longint er);
    int lat, bc;
    bit got;
    lat = 0; bc = 0; got = 0;
    @(posedge clk); #1 next_sample = 1'b1;
    @(posedge clk); #1 next_sample = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) got = 1;
      else if (busy) bc++;
    end
    check({nm, "_valid"}, longint'(got), 1);
    check({nm, "_latency"}, lat, NUM_CH + 3);
    check({nm, "_busy_cycles"}, bc, NUM_CH + 2);
    check({nm, "_left"}, longint'(out_left), el);
    check({nm, "_right"}, longint'(out_right), er);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clip_clear = 1'b1;
    @(posedge clk); #1 clip_clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int nv;
    solo(0, 0, 15, 15);
    #1 rst_n = 1'b0;
    #20 @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_left", longint'(out_left), 0);
    check("reset_busy", longint'(busy), 0);

    solo(1000, -1000, 15, 15);   run_mix("unity", 1000, -1000);
    solo(1600, 0, 8, 15);        run_mix("atten", 800, 0);
    solo(1600, 0, 8, 8);         run_mix("master8", 400, 0);
    solo(-1, 0, 8, 15);          run_mix("floor_neg1", -1, 0);

    // 1000*16 - 300*4 = 14800 -> 925 * 10 = 9250 -> 578 (floor); mirrored right -> -579
    setch(0, 1000, -1000, 15, 1'b0); setch(1, -300, 300, 4, 1'b0);
    setch(2, 7, 7, 0, 1'b0);         setch(3, 12345, 12345, 15, 1'b1);
    mvol = 10;
    run_mix("mixed", 578, -579);

    for (int i = 0; i < NUM_CH; i++) setch(i, 4194303, 0, 15, 1'b0);
    mvol = 15;
    run_mix("sat_pos", 8388607, 0);
    check("clip_left_set", longint'(clip_left), 1);
    check("clip_right_clear", longint'(clip_right), 0);
    for (int i = 0; i < NUM_CH; i++) setch(i, -4194304, 0, 15, 1'b0);
    run_mix("sat_neg", -8388608, 0);
    pulse_clear();
    check("clip_cleared", longint'(clip_left), 0);

    // second strobe at T+2 is dropped; ch0 change at T+1 must not leak into the mix
    solo(1000, -1000, 15, 15);
    @(posedge clk); #1 next_sample = 1'b1;
    @(posedge clk); #1 next_sample = 1'b0;
    @(posedge clk); #1 next_sample = 1'b1; sl[0] = 5;
    @(posedge clk); #1 next_sample = 1'b0;
    nv = 0;
    for (int i = 0; i < 14; i++) begin @(negedge clk); if (out_valid) nv++; end
    check("overrun_one_valid", nv, 1);
    check("snapshot_left", longint'(out_left), 1000);
    check("overrun_flag", longint'(overrun), 1);

    // reset mid-mix, asserted between clock edges
    solo(1600, 1600, 8, 15);
    @(posedge clk); #1 next_sample = 1'b1;
    @(posedge clk); #1 next_sample = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_left", longint'(out_left), 0);
    check("async_rst_right", longint'(out_right), 0);
    check("async_rst_busy", longint'(busy), 0);
    check("async_rst_overrun", longint'(overrun), 0);
    check("async_rst_valid", longint'(out_valid), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (out_valid) nv++; end
    check("aborted_no_valid", nv, 0);
    check("aborted_left_zero", longint'(out_left), 0);
    run_mix("post_reset", 800, 800);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
